db_conv_scheduler: RTL and testbench
====================================

// Module: db_conv_scheduler
// PURPOSE
// Shares one pipelined power-to-dB converter among N_CH per-channel power sources using round-robin arbitration.
// Tags each issued sample with its channel ID in an in-order FIFO, so the converter may have any latency.
// Routes each converter result back to its channel. Sits between the channel power accumulators and the converter.
// PARAMETERS
// N_CH   4   number of requesting channels (2..16)
// PW     32  power sample width, unsigned
// DBW    16  dB result width
// DEPTH  8   max outstanding samples in converter; power of 2, >= converter latency + 1
// PORTS
// clk          in   1         system clock, all logic on rising edge
// rst_n        in   1         asynchronous active-low reset
// ch_valid_i   in   N_CH      per-channel sample valid
// ch_power_i   in   N_CH*PW   per-channel power; channel i at [i*PW +: PW]
// ch_ready_o   out  N_CH      one-hot grant; a transfer occurs when valid&ready
// flush_i      in   1         stop issuing and drain the converter
// pdb_valid_o  out  1         sample valid to converter
// pdb_power_o  out  PW        sample to converter
// pdb_valid_i  in   1         converter result valid
// pdb_dB_i     in   DBW       converter result
// res_valid_o  out  1         routed result strobe
// res_ch_o     out  CHW       channel ID of result; CHW = max(1,$clog2(N_CH))
// res_dB_o     out  DBW       routed result
// ch_dB_o      out  N_CH*DBW  latest dB per channel, held
// drained_o    out  1         in DRAIN state with zero outstanding
// overflow_o   out  1         sticky: result received with tag FIFO empty
// BEHAVIOUR
// - Reset: all outputs 0; rr_ptr=0; outstanding count=0; FIFO empty; state=RUN.
// - FSM RUN: may grant. RUN->DRAIN when flush_i=1.
// - FSM DRAIN: no grants. drained_o = (count==0). DRAIN->RUN when flush_i=0 and count==0.
// - Grant is combinational in the current cycle.
//   - Condition: state==RUN && count<DEPTH && |ch_valid_i.
//   - Winner: first valid channel searching from rr_ptr upward, with wrap.
//   - After a grant to channel g: rr_ptr <= (g+1) mod N_CH. With no grant, rr_ptr holds.
// - Issue is registered. Cycle after a grant: pdb_valid_o=1, pdb_power_o=granted sample, tag g pushed to FIFO.
//   Otherwise pdb_valid_o=0 and pdb_power_o holds its last value.
// - count counts grants not yet returned. It is incremented at grant, so the issue register is included.
//   - Decremented when pdb_valid_i=1 and count>0.
//   - Simultaneous increment and decrement: count is unchanged.
//   - No bypass: the count<DEPTH check uses the current value of count.
// - Result path: pdb_valid_i pops the FIFO head as tag t. Next cycle:
//   res_valid_o=1, res_ch_o=t, res_dB_o=pdb_dB_i, ch_dB_o[t] <= pdb_dB_i.
// - Results return in issue order; a FIFO pop and push in the same cycle are both honoured.
// - pdb_valid_i with count==0: result dropped, res_valid_o stays 0, overflow_o <= 1. Cleared only by reset.
// - The FIFO cannot overflow because count<=DEPTH is guaranteed by the grant rule.
// - Latency from grant to pdb_valid_o: 1 cycle. From pdb_valid_i to res_valid_o: 1 cycle.
// - Reset mid-operation: all tags are lost. The converter must be reset in the same cycle;
//   otherwise late results set overflow_o.
// - flush_i asserted in the same cycle as a would-be grant: grant suppressed (state register updates first).
//   A grant already registered still issues and is counted.
// STRUCTURE
// - dsp_pkg:
//   - typedef enum logic {SCH_RUN, SCH_DRAIN} sched_state_t
//   - function chw(n) for the channel ID width
// - Sub-module tag_fifo (WIDTH=CHW, DEPTH): synchronous, first-word fall-through.
//   Ports push/pop/din/dout/empty/full; async active-low reset.
// - Top level: rotate-priority arbiter, count register, FSM, issue register, result register, per-channel dB bank.
// TESTING
// 1. Single channel: N_CH=4, ch_valid_i=4'b0100, power=1000, converter model latency 5
//    -> pdb_valid_o 1 cycle after grant; res_ch_o=2, res_dB_o=30, 6 cycles after issue.
// 2. All 4 channels valid every cycle
//    -> grant order 0,1,2,3,0,...; each channel gets exactly 25 of 100 grants; results tagged in the same order.
// 3. Backpressure: DEPTH=8, converter latency 20, all channels valid
//    -> exactly 8 grants, then ready all 0 until the first result; count never exceeds 8.
// 4. Flush with 5 outstanding: flush_i=1
//    -> no further grants; drained_o rises the cycle after the 5th result;
//       flush_i=0 resumes grants from rr_ptr.
// 5. Spurious pdb_valid_i with count==0
//    -> overflow_o=1 and held, res_valid_o=0; then reset -> overflow_o=0, all outputs 0.
// 6. Simultaneous grant and result return for 50 cycles
//    -> count constant, FIFO never full or empty, ch_dB_o matches the converter model per channel.

Source files
------------

// File: rtl/db_conv_scheduler_pkg.sv
// Shared types and helpers for the dB converter scheduler.
// Channel-ID width never drops below one bit so two-channel builds still carry a tag.
package dsp_pkg;

  typedef enum logic {SCH_RUN, SCH_DRAIN} sched_state_t;

  function automatic int chw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/db_conv_scheduler_tag_fifo.sv
// In-order channel-tag FIFO, first-word fall-through: dout_o is the head whenever not empty.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign wr_d    = do_push ? wr_q + 1'b1 : wr_q;
  assign rd_d    = do_pop ? rd_q + 1'b1 : rd_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

endmodule

// File: rtl/db_conv_scheduler.sv
// Round-robin scheduler sharing one pipelined power-to-dB converter among N_CH channels,
// tagging each issue with its channel so results are routed back in issue order.
module db_conv_scheduler
  import dsp_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int PW    = 32,
  parameter int DBW   = 16,
  parameter int DEPTH = 8,
  localparam int CHW  = chw(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     ch_valid_i,
  input  logic [N_CH*PW-1:0]  ch_power_i,
  output logic [N_CH-1:0]     ch_ready_o,
  input  logic                flush_i,
  output logic                pdb_valid_o,
  output logic [PW-1:0]       pdb_power_o,
  input  logic                pdb_valid_i,
  input  logic [DBW-1:0]      pdb_dB_i,
  output logic                res_valid_o,
  output logic [CHW-1:0]      res_ch_o,
  output logic [DBW-1:0]      res_dB_o,
  output logic [N_CH*DBW-1:0] ch_dB_o,
  output logic                drained_o,
  output logic                overflow_o
);

  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

  sched_state_t             state_q, state_d;
  logic [CNTW-1:0]          count_q, count_d;
  logic [CHW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [CHW-1:0]           grant_ch, idx;
  logic                     grant_any, grant;
  logic                     pdb_valid_q;
  logic [PW-1:0]            pdb_power_q;
  logic                     res_valid_q;
  logic [CHW-1:0]           res_ch_q;
  logic [DBW-1:0]           res_dB_q;
  logic [N_CH-1:0][DBW-1:0] ch_dB_q;
  logic                     overflow_q;
  logic                     fifo_empty, fifo_full, pop;
  logic [CHW-1:0]           fifo_tag;

  // First valid channel at or after rr_ptr, wrapping around.
  always_comb begin
    grant_any = 1'b0;
    grant_ch  = '0;
    idx       = '0;
    for (int off = 0; off < N_CH; off++) begin
      idx = CHW'((int'(rr_ptr_q) + off) % N_CH);
      if (!grant_any && ch_valid_i[idx]) begin
        grant_any = 1'b1;
        grant_ch  = idx;
      end
    end
  end

  assign grant      = (state_q == SCH_RUN) && !flush_i && (count_q < DEPTH_C) && !fifo_full && grant_any;
  assign ch_ready_o = grant ? (N_CH'(1) << grant_ch) : '0;
  assign rr_ptr_d   = grant ? CHW'((int'(grant_ch) + 1) % N_CH) : rr_ptr_q;
  assign pop        = pdb_valid_i && !fifo_empty;

  always_comb begin
    count_d = count_q;
    case ({grant, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCH_RUN:   if (flush_i) state_d = SCH_DRAIN;
      SCH_DRAIN: if (!flush_i && count_q == '0) state_d = SCH_RUN;
      default:   state_d = SCH_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SCH_RUN;
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Tags are pushed on the grant edge so the head is ready by the time the sample issues.
  tag_fifo #(
    .WIDTH (CHW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (grant),
    .pop_i   (pop),
    .din_i   (grant_ch),
    .dout_o  (fifo_tag),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pdb_valid_q <= 1'b0;
      pdb_power_q <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_dB_q    <= '0;
      ch_dB_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      pdb_valid_q <= grant;
      if (grant) pdb_power_q <= ch_power_i[grant_ch*PW +: PW];
      res_valid_q <= pop;
      if (pop) begin
        res_ch_q          <= fifo_tag;
        res_dB_q          <= pdb_dB_i;
        ch_dB_q[fifo_tag] <= pdb_dB_i;
      end
      if (pdb_valid_i && fifo_empty) overflow_q <= 1'b1;
    end
  end

  assign pdb_valid_o = pdb_valid_q;
  assign pdb_power_o = pdb_power_q;
  assign res_valid_o = res_valid_q;
  assign res_ch_o    = res_ch_q;
  assign res_dB_o    = res_dB_q;
  assign ch_dB_o     = ch_dB_q;
  assign drained_o   = (state_q == SCH_DRAIN) && (count_q == '0);
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_db_conv_scheduler.sv
// Randomized bench for db_conv_scheduler: a queue-based reference model plus a fixed-latency
// converter model, compared cycle by cycle through one checking task.
module tb_db_conv_scheduler;

  localparam int N_CH  = 4;
  localparam int PW    = 32;
  localparam int DBW   = 16;
  localparam int DEPTH = 8;
  localparam int CHW   = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_CH-1:0]     ch_valid_i;
  logic [N_CH*PW-1:0]  ch_power_i;
  logic [N_CH-1:0]     ch_ready_o;
  logic                flush_i;
  logic                pdb_valid_o;
  logic [PW-1:0]       pdb_power_o;
  logic                pdb_valid_i;
  logic [DBW-1:0]      pdb_dB_i;
  logic                res_valid_o;
  logic [CHW-1:0]      res_ch_o;
  logic [DBW-1:0]      res_dB_o;
  logic [N_CH*DBW-1:0] ch_dB_o;
  logic                drained_o;
  logic                overflow_o;

  db_conv_scheduler #(
    .N_CH  (N_CH),
    .PW    (PW),
    .DBW   (DBW),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_valid_i  (ch_valid_i),
    .ch_power_i  (ch_power_i),
    .ch_ready_o  (ch_ready_o),
    .flush_i     (flush_i),
    .pdb_valid_o (pdb_valid_o),
    .pdb_power_o (pdb_power_o),
    .pdb_valid_i (pdb_valid_i),
    .pdb_dB_i    (pdb_dB_i),
    .res_valid_o (res_valid_o),
    .res_ch_o    (res_ch_o),
    .res_dB_o    (res_dB_o),
    .ch_dB_o     (ch_dB_o),
    .drained_o   (drained_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DBW-1:0] db;
  } conv_t;

  conv_t          convQ[$];
  int             tagQ[$];
  int             rr;
  bit             mDrain;
  bit             expPdbV;
  logic [PW-1:0]  expPdbP;
  bit             expResV;
  int             expResCh;
  logic [DBW-1:0] expResDb;
  logic [DBW-1:0] mChDb[N_CH];
  bit             expOvf;
  int             cyc;
  int             lat;
  int             vectors;
  int             miscompares;
  int             obsGrants[N_CH];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [DBW-1:0] dbOf(input logic [PW-1:0] p);
    if (p == 0) return '0;
    return DBW'($rtoi(10.0 * $log10(real'(p)) + 0.5));
  endfunction

  function automatic logic [63:0] packChDb();
    logic [63:0] v = '0;
    for (int i = 0; i < N_CH; i++) v[i*DBW +: DBW] = mChDb[i];
    return v;
  endfunction

  task automatic checkRegs();
    checkOutput("pdb_valid", 64'(pdb_valid_o), 64'(expPdbV));
    checkOutput("pdb_power", 64'(pdb_power_o), 64'(expPdbP));
    checkOutput("res_valid", 64'(res_valid_o), 64'(expResV));
    checkOutput("res_ch",    64'(res_ch_o),    64'(expResCh));
    checkOutput("res_dB",    64'(res_dB_o),    64'(expResDb));
    checkOutput("ch_dB",     64'(ch_dB_o),     packChDb());
    checkOutput("overflow",  64'(overflow_o),  64'(expOvf));
  endtask

  task automatic doReset();
    rst_n       = 1'b0;
    ch_valid_i  = '0;
    ch_power_i  = '0;
    flush_i     = 1'b0;
    pdb_valid_i = 1'b0;
    pdb_dB_i    = '0;
    convQ.delete();
    tagQ.delete();
    rr = 0; mDrain = 0; expPdbV = 0; expPdbP = '0;
    expResV = 0; expResCh = 0; expResDb = '0; expOvf = 0;
    for (int i = 0; i < N_CH; i++) mChDb[i] = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    checkRegs();
    checkOutput("rst_ready",   64'(ch_ready_o), 64'd0);
    checkOutput("rst_drained", 64'(drained_o),  64'd0);
  endtask

  // One full clock cycle: drive inputs, check grant and drain flag, advance the model, clock, check registers.
  task automatic applyStimulus(input logic [N_CH-1:0] vld, input bit flush, input bit spur,
                               input logic [PW-1:0] pwr);
    logic [PW-1:0] pw[N_CH];
    int g;
    int sizeBefore;
    for (int i = 0; i < N_CH; i++) begin
      pw[i] = (pwr != 0) ? pwr : PW'($urandom);
      ch_power_i[i*PW +: PW] = pw[i];
    end
    ch_valid_i  = vld;
    flush_i     = flush;
    pdb_valid_i = 1'b0;
    pdb_dB_i    = DBW'($urandom);
    if (convQ.size() > 0 && convQ[0].due == cyc) begin
      pdb_valid_i = 1'b1;
      pdb_dB_i    = convQ[0].db;
      void'(convQ.pop_front());
    end else if (spur && tagQ.size() == 0 && convQ.size() == 0) begin
      pdb_valid_i = 1'b1;
    end
    #1;
    sizeBefore = tagQ.size();
    g = -1;
    if (!mDrain && !flush && sizeBefore < DEPTH) begin
      for (int off = 0; off < N_CH; off++) begin
        if (g < 0 && vld[(rr + off) % N_CH]) g = (rr + off) % N_CH;
      end
    end
    checkOutput("ready",   64'(ch_ready_o), (g >= 0) ? (64'd1 << g) : 64'd0);
    checkOutput("drained", 64'(drained_o),  64'(mDrain && sizeBefore == 0));
    for (int i = 0; i < N_CH; i++) if (ch_ready_o[i]) obsGrants[i]++;
    expResV = 0;
    if (pdb_valid_i) begin
      if (tagQ.size() > 0) begin
        expResCh = tagQ.pop_front();
        expResV  = 1;
        expResDb = pdb_dB_i;
        mChDb[expResCh] = pdb_dB_i;
      end else begin
        expOvf = 1;
      end
    end
    if (!mDrain) mDrain = flush;
    else if (!flush && sizeBefore == 0) mDrain = 0;
    expPdbV = 0;
    if (g >= 0) begin
      tagQ.push_back(g);
      expPdbV = 1;
      expPdbP = pw[g];
      rr = (g + 1) % N_CH;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (expPdbV) convQ.push_back('{cyc + lat, dbOf(expPdbP)});
    checkRegs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int sum;
    bit fl;
    int lats[4] = '{1, 2, 7, 12};
    vectors = 0; miscompares = 0; cyc = 0; lat = 5;
    for (int i = 0; i < N_CH; i++) obsGrants[i] = 0;
    doReset();

    // Lone request on channel 2 with a 5-cycle converter.
    applyStimulus(4'b0100, 1'b0, 1'b0, 32'd1000);
    idle(10);
    checkOutput("tc1_dB", 64'(ch_dB_o[2*DBW +: DBW]), 64'd30);

    // Every channel requesting continuously: strict rotation, equal share.
    lat = 3;
    for (int i = 0; i < N_CH; i++) obsGrants[i] = 0;
    for (int i = 0; i < 100; i++) applyStimulus('1, 1'b0, 1'b0, '0);
    for (int i = 0; i < N_CH; i++) checkOutput($sformatf("share_ch%0d", i), 64'(obsGrants[i]), 64'd25);
    idle(lat + 3);

    // Long converter latency: the outstanding limit must stall the arbiter.
    lat = 20;
    for (int i = 0; i < N_CH; i++) obsGrants[i] = 0;
    for (int i = 0; i < 20; i++) applyStimulus('1, 1'b0, 1'b0, '0);
    sum = 0;
    for (int i = 0; i < N_CH; i++) sum += obsGrants[i];
    checkOutput("backpressure_grants", 64'(sum), 64'(DEPTH));
    for (int i = 0; i < 20; i++) applyStimulus('1, 1'b0, 1'b0, '0);
    idle(lat + 3);

    // Flush with traffic in flight, hold until drained, then release.
    lat = 6;
    for (int i = 0; i < 5; i++) applyStimulus('1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 12; i++) applyStimulus('1, 1'b1, 1'b0, '0);
    checkOutput("flush_drained", 64'(drained_o), 64'd1);
    for (int i = 0; i < 8; i++) applyStimulus('1, 1'b0, 1'b0, '0);
    idle(lat + 3);

    // Random traffic, random flush episodes and stray converter strobes at several latencies.
    for (int k = 0; k < 4; k++) begin
      lat = lats[k];
      fl  = 0;
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 19) == 0) fl = !fl;
        applyStimulus(N_CH'($urandom), fl, ($urandom_range(0, 15) == 0), '0);
      end
      idle(lat + 3);
    end

    // Stray result with nothing outstanding, then reset mid-operation.
    idle(2);
    applyStimulus('0, 1'b0, 1'b1, '0);
    checkOutput("overflow_set", 64'(overflow_o), 64'd1);
    idle(3);
    lat = 10;
    for (int i = 0; i < 6; i++) applyStimulus('1, 1'b0, 1'b0, '0);
    doReset();
    lat = 4;
    for (int i = 0; i < 20; i++) applyStimulus(N_CH'($urandom), 1'b0, 1'b0, '0);
    idle(lat + 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
